// File: rtl/uart_rxd.sv
`default_nettype none
// ============================================================================
// Module      : uart_rxd
// Description : UART receiver that samples the line at mid-bit for 8N1/8E1/8O1
//               frames and reports each byte with parity and framing status.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rxd #(
    parameter int SYS_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic [1:0] parity,
    output logic [7:0] rxd_data,
    output logic       rxd_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rxd_busy
);
    localparam int BAUD_DR = SYS_FREQ / BAUD;
    localparam int CNT_W   = (BAUD_DR > 1) ? $clog2(BAUD_DR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DR - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DR / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rs1_q, rs2_q, rs3_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       par_q, par_d;
    logic             perr_pend_q, perr_pend_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             w_start_edge;
    logic             w_sample;
    logic             w_par_exp;

    assign w_start_edge = armed_q & rs3_q & ~rs2_q;
    assign w_sample     = (cnt_q == CNT_MID);
    assign w_par_exp    = par_q[0] ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= 1'b1;
            rs2_q       <= 1'b1;
            rs3_q       <= 1'b1;
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 2'b00;
            perr_pend_q <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rs1_q       <= rxd;
            rs2_q       <= rs1_q;
            rs3_q       <= rs2_q;
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            perr_pend_q <= perr_pend_d;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        // Re-arm as soon as the line is seen idle; a low stop bit disarms below.
        armed_d     = armed_q | rs2_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        perr_pend_d = perr_pend_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_start_edge) begin
                    state_d     = S_START;
                    par_d       = parity;
                    perr_pend_d = 1'b0;
                end
            end
            S_START: begin
                bit_d = 3'd0;
                if (w_sample) begin
                    state_d = rs2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    shift_d = {rs2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = par_q[1] ? S_STOP : S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    perr_pend_d = (rs2_q != w_par_exp);
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving mid-stop-bit lets an immediately following start edge be caught.
                if (w_sample) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    data_d  = shift_q;
                    perr_d  = perr_pend_q;
                    ferr_d  = ~rs2_q;
                    if (!rs2_q) begin
                        armed_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rxd_data   = data_q;
    assign rxd_done   = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rxd_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rxd.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rxd
// Description : Directed self-checking bench for uart_rxd at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rxd;
    localparam int DR = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [1:0] parity;
    logic [7:0] rxd_data;
    logic       rxd_done;
    logic       parity_err;
    logic       frame_err;
    logic       rxd_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_base;
    int start_cyc;
    int last_done_cyc = 0;
    logic [9:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [1:0] pm;
    logic [9:0] obs;

    always #5 clk = ~clk;

    uart_rxd #(
        .SYS_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .parity     (parity),
        .rxd_data   (rxd_data),
        .rxd_done   (rxd_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rxd_busy   (rxd_busy)
    );

    // Record every strobe with the status it delivered.
    always @(negedge clk) begin
        cyc++;
        if (rxd_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            rx_q.push_back({frame_err, parity_err, rxd_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic tx_par(input logic [7:0] d, input logic [1:0] m);
        return (m == 2'b00) ? ^d : ~^d;
    endfunction

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rxd = v;
        repeat (DR - 1) @(negedge clk);
    endtask

    // chg_bit: data bit before which parity input is changed; rst_bit: data bit during which reset is asserted.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input logic pbit,
                              input logic stopb, input int chg_bit, input logic [1:0] chg_val,
                              input int rst_bit);
        parity = m;
        @(negedge clk);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (DR - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) parity = chg_val;
            if (i == rst_bit) begin
                @(negedge clk);
                rxd = d[i];
                repeat (DR / 2) @(negedge clk);
                rst_n = 1'b0;
                return;
            end
            drive_bit(d[i]);
        end
        if (!m[1]) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, done_cnt - done_base, 1);
        chk({tag, "_data"}, rxd_data, d);
        chk({tag, "_perr"}, parity_err, pe);
        chk({tag, "_ferr"}, frame_err, fe);
        chk({tag, "_busy"}, rxd_busy, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rxd    = 1'b1;
        parity = 2'b10;
        repeat (3) @(negedge clk);
        chk("rst_data", rxd_data, 0);
        chk("rst_done", rxd_done, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", rxd_busy, 0);
        rst_n = 1'b1;
        repeat (2 * DR) @(negedge clk);

        // 8N1 0x55 plus strobe latency of about 9.5 bit periods
        done_base = done_cnt;
        send_frame(8'h55, 2'b10, 1'b0, 1'b1, -1, 2'b00, -1);
        expect_frame("n1_55", 8'h55, 1'b0, 1'b0);
        chk("n1_latency", (last_done_cyc - start_cyc >= 148) && (last_done_cyc - start_cyc <= 162), 1);

        // 8E1 0xA3: parity bit 0 correct, 1 wrong
        done_base = done_cnt;
        send_frame(8'hA3, 2'b00, 1'b0, 1'b1, -1, 2'b00, -1);
        expect_frame("e1_a3_ok", 8'hA3, 1'b0, 1'b0);
        done_base = done_cnt;
        send_frame(8'hA3, 2'b00, 1'b1, 1'b1, -1, 2'b00, -1);
        expect_frame("e1_a3_bad", 8'hA3, 1'b1, 1'b0);

        // 8O1 0x01 with parity input switched to none mid-frame
        done_base = done_cnt;
        send_frame(8'h01, 2'b01, 1'b0, 1'b1, 4, 2'b10, -1);
        expect_frame("o1_01_chg", 8'h01, 1'b0, 1'b0);

        // Short low glitch is a false start
        done_base = done_cnt;
        parity = 2'b10;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_hi", rxd_busy, 1);
        @(negedge clk);
        rxd = 1'b1;
        repeat (14) @(negedge clk);
        chk("glitch_busy_lo", rxd_busy, 0);
        chk("glitch_nodone", done_cnt - done_base, 0);
        send_frame(8'h3C, 2'b10, 1'b0, 1'b1, -1, 2'b00, -1);
        expect_frame("after_glitch", 8'h3C, 1'b0, 1'b0);

        // Break: stop bit low, line held low
        done_base = done_cnt;
        send_frame(8'h00, 2'b10, 1'b0, 1'b0, -1, 2'b00, -1);
        repeat (5000) @(negedge clk);
        chk("break_done", done_cnt - done_base, 1);
        chk("break_ferr", frame_err, 1);
        chk("break_data", rxd_data, 8'h00);
        rxd = 1'b1;
        repeat (2 * DR) @(negedge clk);
        done_base = done_cnt;
        send_frame(8'h7E, 2'b10, 1'b0, 1'b1, -1, 2'b00, -1);
        expect_frame("after_break", 8'h7E, 1'b0, 1'b0);

        // Asynchronous reset during data bit 3
        done_base = done_cnt;
        send_frame(8'hC9, 2'b00, 1'b0, 1'b1, -1, 2'b00, 3);
        #1;
        chk("mid_rst_data", rxd_data, 0);
        chk("mid_rst_busy", rxd_busy, 0);
        chk("mid_rst_done", rxd_done, 0);
        @(negedge clk);
        @(negedge clk);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (2 * DR) @(negedge clk);
        chk("mid_rst_nostrobe", done_cnt - done_base, 0);
        send_frame(8'hC9, 2'b00, 1'b0, 1'b1, -1, 2'b00, -1);
        expect_frame("after_rst_c9", 8'hC9, 1'b0, 1'b0);

        // Back-to-back loopback frames in each parity mode
        for (int m = 0; m < 3; m++) begin
            pm = 2'(m);
            rx_q.delete();
            exp_q.delete();
            for (int k = 0; k < 32; k++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_frame(b, pm, tx_par(b, pm), 1'b1, -1, 2'b00, -1);
            end
            repeat (DR) @(negedge clk);
            chk("loop_count", rx_q.size(), 32);
            for (int k = 0; k < exp_q.size(); k++) begin
                obs = (k < rx_q.size()) ? rx_q[k] : 10'h3FF;
                chk("loop_byte", obs, {2'b00, exp_q[k]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
